fp_align_add: RTL and testbench
===============================

Name: fp_align_add

Overview:
- Two-stage pipelined front end of the single-precision FP adder.
- Unpacks two IEEE-754 binary32 operands, orders them by magnitude and aligns the smaller mantissa by right shift.
- Adds or subtracts the magnitudes and delivers a 25-bit unsigned mantissa sum plus the larger exponent to the downstream normalisation/priority-encode stage.
- valid/ready handshake on both sides; full throughput of one operation per cycle.

Parameters:
- SHIFT_LIMIT, 25, exponent difference at or above which the aligned smaller mantissa becomes all zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- op_a  in  32  binary32 operand A.
- op_b  in  32  binary32 operand B.
- op_sub  in  1  1 = A - B (B sign inverted), 0 = A + B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- mant_sum  out  25  {carry, hidden, frac[22:0]}, unsigned magnitude of the result.
- exp_big  out  8  biased exponent of the larger-magnitude operand (denormals reported as 1).
- sign_out  out  1  result sign.
- zero_out  out  1  mant_sum == 0.

Behaviour:
- Reset: synchronous, active-high. While rst is high at a clock edge, s1_valid and s2_valid clear. out_valid, mant_sum, exp_big, sign_out and zero_out are 0 the cycle after reset. in_ready is 1 once rst is low.
- Reset mid-operation: in-flight data is discarded with no partial output.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational). No combinational path from in_valid to out_valid.
  - out_* hold stable while out_valid & !out_ready.
- Latency: 2 cycles, from input accept edge to out_valid high. Back-to-back issue gives one result per cycle.
- Stage 1 (register on adv1), unpack and order:
  - For each operand, e = exp field. If e == 0: hidden bit 0 and effective exponent 1 (denormal/zero). Otherwise hidden bit 1.
  - sb_eff = sign_b ^ op_sub.
  - Big = operand with larger {eff_exp, hidden, frac}. On a tie, A is big.
  - Register the big/small 24-bit mantissas, exp_big, diff = exp_big - exp_small (8-bit unsigned), eff_sub = sign_a ^ sb_eff, and sign_big.
- Stage 2 (register on adv2), align and add:
  - If diff >= SHIFT_LIMIT, the aligned small mantissa is 0. Otherwise it is m_small >> diff; shifted-out bits are dropped.
  - If eff_sub = 0: mant_sum = {1'b0, m_big} + {1'b0, m_small_al}.
  - If eff_sub = 1: mant_sum = {1'b0, m_big} - {1'b0, m_small_al}, never negative by construction.
  - sign_out = sign_big, except exact cancellation (mant_sum == 0 with eff_sub = 1) forces sign_out = 0.
  - zero_out = (mant_sum == 0).
- No NaN/Inf special-casing here; all-ones exponents pass through arithmetically and the downstream stage owns exceptions.
- Simultaneous input accept and output drain in the same cycle: both stages advance, and nothing is lost or duplicated.

Optional Feature:
- Macro FP_ALIGN_GRS_EN.
- When defined:
  - Adds output port grs [2:0].
  - Guard and round are the two bits shifted out immediately below the LSB; sticky is the OR of all lower shifted-out bits.
  - For diff >= SHIFT_LIMIT, sticky = |m_small.
  - grs is registered alongside mant_sum and resets to 0.
  - For eff_sub, grs is carried unmodified (the downstream stage performs the borrow correction).
- When undefined: no grs port; shifted-out bits are discarded.

Test Plan:
- Add equal: op_a=0x3F800000, op_b=0x3F800000, op_sub=0 -> 2 cycles later mant_sum=0x1000000, exp_big=0x7F, sign_out=0, zero_out=0.
- Cancellation: op_a=0x3F800000, op_b=0x3F800000, op_sub=1 -> mant_sum=0, zero_out=1, sign_out=0. Repeat with op_a=0xBF800000, op_b=0xBF800000, op_sub=1 -> sign_out=0.
- Subtract with swap: op_a=0x3F800000, op_b=0x3FC00000, op_sub=1 -> mant_sum=0x0400000, exp_big=0x7F, sign_out=1.
- Large exponent gap: op_a=0x3F800000, op_b=0x30800000 (diff=30), op_sub=0 -> mant_sum=0x0800000. With FP_ALIGN_GRS_EN, grs=3'b001.
- Backpressure: hold out_ready=0 while offering 3 back-to-back pairs -> first two accepted and in_ready drops. Release out_ready -> 3 results in order, no drop/duplicate, out_* stable while stalled.
- Reset mid-flight: assert rst for 1 cycle with both stages valid -> out_valid=0 on the next cycle, all outputs 0, in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/fp_align_add.sv
// Binary32 adder front end: unpack/order, then align/add. Latency 2 (accept edge -> out_valid), one op/cycle.
// Stages hold under out_ready low, and in_ready is the stage-1 advance. FP_ALIGN_GRS_EN adds the guard/round/sticky output grs.
module fp_align_add #(
  parameter int unsigned SHIFT_LIMIT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] mant_sum,
  output logic [7:0]  exp_big,
  output logic        sign_out,
  output logic        zero_out
`ifdef FP_ALIGN_GRS_EN
  ,
  output logic [2:0]  grs
`endif
);

  localparam logic [31:0] LIM32 = SHIFT_LIMIT;
  localparam logic [7:0]  LIM   = LIM32[7:0];

  logic        r_s1_valid, r_s2_valid;
  logic [23:0] r_m_big, r_m_small;
  logic [7:0]  r_exp_big, r_diff;
  logic        r_eff_sub, r_sign_big;
  logic [24:0] r_mant_sum;
  logic [7:0]  r_exp_out;
  logic        r_sign_out, r_zero_out;

  logic        w_adv1, w_adv2;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  logic        w_sb_eff, w_a_big;
  logic [23:0] w_al;
  logic [24:0] w_sum;
  logic        w_sign;

  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  // Zero exponent field means denormal/zero: no hidden bit, effective exponent 1.
  assign w_ea     = (op_a[30:23] == 8'd0) ? 8'd1 : op_a[30:23];
  assign w_eb     = (op_b[30:23] == 8'd0) ? 8'd1 : op_b[30:23];
  assign w_ma     = {|op_a[30:23], op_a[22:0]};
  assign w_mb     = {|op_b[30:23], op_b[22:0]};
  assign w_sb_eff = op_b[31] ^ op_sub;
  assign w_a_big  = {w_ea, w_ma} >= {w_eb, w_mb};

`ifdef FP_ALIGN_GRS_EN
  logic [47:0] w_ext;
  logic [2:0]  w_grs;
  logic [2:0]  r_grs;
  // The low half of the widened shift holds every bit that falls off the aligned mantissa.
  assign w_ext = {r_m_small, 24'd0} >> r_diff;
  assign w_al  = (r_diff >= LIM) ? 24'd0 : w_ext[47:24];
  assign w_grs = (r_diff >= LIM) ? {2'b00, |r_m_small} : {w_ext[23], w_ext[22], |w_ext[21:0]};
  assign grs   = r_grs;
`else
  assign w_al  = (r_diff >= LIM) ? 24'd0 : (r_m_small >> r_diff);
`endif

  assign w_sum  = r_eff_sub ? ({1'b0, r_m_big} - {1'b0, w_al}) : ({1'b0, r_m_big} + {1'b0, w_al});
  assign w_sign = (r_eff_sub && (w_sum == 25'd0)) ? 1'b0 : r_sign_big;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_m_big    <= '0;
      r_m_small  <= '0;
      r_exp_big  <= '0;
      r_diff     <= '0;
      r_eff_sub  <= 1'b0;
      r_sign_big <= 1'b0;
      r_mant_sum <= '0;
      r_exp_out  <= '0;
      r_sign_out <= 1'b0;
      r_zero_out <= 1'b0;
`ifdef FP_ALIGN_GRS_EN
      r_grs      <= '0;
`endif
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_m_big    <= w_a_big ? w_ma : w_mb;
          r_m_small  <= w_a_big ? w_mb : w_ma;
          r_exp_big  <= w_a_big ? w_ea : w_eb;
          r_diff     <= w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
          r_eff_sub  <= op_a[31] ^ w_sb_eff;
          r_sign_big <= w_a_big ? op_a[31] : w_sb_eff;
        end
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_mant_sum <= w_sum;
          r_exp_out  <= r_exp_big;
          r_sign_out <= w_sign;
          r_zero_out <= (w_sum == 25'd0);
`ifdef FP_ALIGN_GRS_EN
          r_grs      <= w_grs;
`endif
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign mant_sum  = r_mant_sum;
  assign exp_big   = r_exp_out;
  assign sign_out  = r_sign_out;
  assign zero_out  = r_zero_out;

endmodule

// File: tb/tb_fp_align_add.sv
// Bench for fp_align_add: directed vector table, hand-written stall/reset sequences, randomized traffic vs. model.
module tb_fp_align_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready, sign_out, zero_out;
  logic [31:0] op_a, op_b;
  logic [24:0] mant_sum;
  logic [7:0]  exp_big;
`ifdef FP_ALIGN_GRS_EN
  logic [2:0]  grs;
`endif

  fp_align_add dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_sum(mant_sum), .exp_big(exp_big), .sign_out(sign_out), .zero_out(zero_out)
`ifdef FP_ALIGN_GRS_EN
    , .grs(grs)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [24:0] mant;
    logic [7:0]  e;
    logic        s;
    logic        z;
    logic [2:0]  grs;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    res_t        r;
  } vec_t;

  // Reference: magnitudes as integers, alignment as integer division by 2**d.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t   r;
    longint ea, eb, ma, mb, ebig, esml, big, sml, d, al, sum, lost;
    logic   sa, sb, abig, eff, sbig, g, rd, st;
    ea = (a[30:23] == 8'd0) ? 64'd1 : longint'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 64'd1 : longint'(b[30:23]);
    ma = longint'(a[22:0]) + ((a[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    mb = longint'(b[22:0]) + ((b[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    sa = a[31];
    sb = b[31] ^ sub;
    abig = (ea > eb) || ((ea == eb) && (ma >= mb));
    ebig = abig ? ea : eb;  esml = abig ? eb : ea;
    big  = abig ? ma : mb;  sml  = abig ? mb : ma;
    sbig = abig ? sa : sb;
    eff  = sa ^ sb;
    d    = ebig - esml;
    al   = (d >= 25) ? 64'd0 : sml / (64'd1 << d);
    sum  = eff ? big - al : big + al;
    r.mant = 25'(sum);
    r.e    = 8'(ebig);
    r.z    = (sum == 0);
    r.s    = (eff && sum == 0) ? 1'b0 : sbig;
    if (d >= 25) begin
      r.grs = {2'b00, sml != 0};
    end else begin
      lost = (d == 0) ? 64'd0 : sml % (64'd1 << d);
      g  = (d >= 1) && (((lost >> (d - 1)) & 64'd1) != 0);
      rd = (d >= 2) && (((lost >> (d - 2)) & 64'd1) != 0);
      st = (d >= 3) && ((lost % (64'd1 << (d - 2))) != 0);
      r.grs = {g, rd, st};
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op(input logic [7:0] base);
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 5))
      0:       e = 8'd0;
      1:       e = 8'($urandom_range(0, 255));
      default: e = base + 8'($urandom_range(0, 30));
    endcase
    f = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  task automatic chk_res(input string tag, input res_t exp);
    chk({tag, "_mant"}, 32'(mant_sum), 32'(exp.mant));
    chk({tag, "_exp"},  32'(exp_big),  32'(exp.e));
    chk({tag, "_sign"}, 32'(sign_out), 32'(exp.s));
    chk({tag, "_zero"}, 32'(zero_out), 32'(exp.z));
`ifdef FP_ALIGN_GRS_EN
    chk({tag, "_grs"},  32'(grs),      32'(exp.grs));
`endif
  endtask

  // Streaming monitor: scoreboard queue plus hold-while-stalled check.
  logic        mon_en = 1'b0;
  res_t        sbq[$];
  logic        was_stall = 1'b0;
  logic [24:0] st_mant;
  logic [7:0]  st_exp;
  logic        st_sign;

  always @(negedge clk) begin
    if (mon_en) begin
      if (was_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_mant",  32'(mant_sum), 32'(st_mant));
        chk("stall_exp",   32'(exp_big),  32'(st_exp));
        chk("stall_sign",  32'(sign_out), 32'(st_sign));
      end
      was_stall = out_valid && !out_ready;
      st_mant = mant_sum; st_exp = exp_big; st_sign = sign_out;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_extra: got an output, required none (scoreboard empty)");
        end else begin
          chk_res("rnd", sbq.pop_front());
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(op_a, op_b, op_sub));
    end
  end

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; op_a = a; op_b = b; op_sub = s; out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t tbl[9];
  res_t bp_exp[3];
  logic [31:0] bp_a[3], bp_b[3];

  initial begin
    int lat, n;
    tbl[0] = '{32'h3F800000, 32'h3F800000, 1'b0, '{25'h1000000, 8'h7F, 1'b0, 1'b0, 3'b000}};
    tbl[1] = '{32'h3F800000, 32'h3F800000, 1'b1, '{25'h0000000, 8'h7F, 1'b0, 1'b1, 3'b000}};
    tbl[2] = '{32'hBF800000, 32'hBF800000, 1'b1, '{25'h0000000, 8'h7F, 1'b0, 1'b1, 3'b000}};
    tbl[3] = '{32'h3F800000, 32'h3FC00000, 1'b1, '{25'h0400000, 8'h7F, 1'b1, 1'b0, 3'b000}};
    tbl[4] = '{32'h3F800000, 32'h30800000, 1'b0, '{25'h0800000, 8'h7F, 1'b0, 1'b0, 3'b001}};
    tbl[5] = '{32'h00000001, 32'h00000001, 1'b0, '{25'h0000002, 8'h01, 1'b0, 1'b0, 3'b000}};
    tbl[6] = '{32'h3F800000, 32'h33800000, 1'b0, '{25'h0800000, 8'h7F, 1'b0, 1'b0, 3'b100}};
    tbl[7] = '{32'h40000000, 32'h3F800000, 1'b0, '{25'h0C00000, 8'h80, 1'b0, 1'b0, 3'b000}};
    tbl[8] = '{32'hC0000000, 32'h3FC00000, 1'b0, '{25'h0200000, 8'h80, 1'b1, 1'b0, 3'b000}};

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mant",      32'(mant_sum),  32'd0);
    chk("rst_exp",       32'(exp_big),   32'd0);
    chk("rst_sign",      32'(sign_out),  32'd0);
    chk("rst_zero",      32'(zero_out),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef FP_ALIGN_GRS_EN
    chk("rst_grs",       32'(grs),       32'd0);
`endif

    for (int i = 0; i < 9; i++) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].sub, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk_res($sformatf("v%0d", i), tbl[i].r);
    end

    // Backpressure: three back-to-back offers with the sink stalled.
    bp_a[0] = 32'h40490FDB; bp_b[0] = 32'h3F000000;
    bp_a[1] = 32'hC1200000; bp_b[1] = 32'h41200001;
    bp_a[2] = 32'h3E800000; bp_b[2] = 32'h42C80000;
    for (int i = 0; i < 3; i++) bp_exp[i] = model(bp_a[i], bp_b[i], i[0]);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op_a = bp_a[i]; op_b = bp_b[i]; op_sub = i[0];
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), (i < 2) ? 32'd1 : 32'd0);
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk_res("bp_head", bp_exp[0]);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk_res("bp_hold", bp_exp[0]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (n < 3) chk_res($sformatf("bp_out%0d", n), bp_exp[n]);
        n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("bp_count", 32'(n), 32'd3);

    // Reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1;
    op_a = tbl[0].a; op_b = tbl[0].b; op_sub = tbl[0].sub;
    @(posedge clk); #1;
    op_a = tbl[3].a; op_b = tbl[3].b; op_sub = tbl[3].sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_mant",      32'(mant_sum),  32'd0);
    chk("mid_exp",       32'(exp_big),   32'd0);
    chk("mid_sign",      32'(sign_out),  32'd0);
    chk("mid_zero",      32'(zero_out),  32'd0);
    chk("mid_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_no_leftover%0d", k), 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure.
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      logic [7:0] base;
      base      = 8'($urandom_range(0, 230));
      in_valid  = ($urandom_range(0, 9) < 7);
      op_a      = rnd_op(base);
      op_b      = ($urandom_range(0, 7) == 0) ? op_a : rnd_op(base);
      op_sub    = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("drain_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
